branch_target_table: RTL

- Parametrised, run-time writable branch-target table.
- Maps a branch index to a target PC for the program counter/fetch logic.
- Successor to the fixed 64x7 combinational target LUT: adds a write port, registered reads with a valid strobe, and same-cycle write-to-read bypass.
- Adds a post-reset initialisation sequencer that loads the default target set one entry per cycle.

---
 rtl/branch_target_table.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_target_table.sv
// Run-time writable branch-target table: registered reads with valid strobe,
// same-cycle write-to-read bypass, and a post-reset sequencer that loads default targets.
module branch_target_table #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_index,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_miss,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_index,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              busy_reg, busy_next;

    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_miss_reg;
    logic              wr_err_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] default_rom [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              rd_fire;
    logic              bypass_hit;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [DATA_W-1:0] default_target(input int idx);
        case (idx)
            0, 1:    return DATA_W'(12);
            2:       return DATA_W'(15);
            3:       return DATA_W'(30);
            4:       return DATA_W'(36);
            5:       return DATA_W'(33);
            6:       return DATA_W'(28);
            7:       return DATA_W'(48);
            default: return '0;
        endcase
    endfunction

    // Default image, one constant per entry; folds to a small ROM indexed by the init counter.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_default_rom
            assign default_rom[gi] = default_target(gi);
        end
    endgenerate

    // Sequencer: INIT walks every entry once, then parks in RUN until the next reset.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_next == (ADDR_W + 1)'(DEPTH)) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        busy_next = (state_next == ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
        end
    end

    // Single write port shared by the sequencer and user writes; user writes lose during INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_index;
        mem_wdata = wr_data;
        if (!reset) begin
            if (state_reg == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_reg[ADDR_W-1:0];
                mem_wdata = default_rom[cnt_reg[ADDR_W-1:0]];
            end else if (wr_en) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_fire    = (state_reg == ST_RUN) && rd_req;
    assign bypass_hit = (state_reg == ST_RUN) && wr_en && (wr_index == rd_index);
    assign rd_word    = bypass_hit ? wr_data : mem[rd_index];

    // Read data and miss flag only update on a fired read so they hold between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_miss_reg  <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire;
            wr_err_reg   <= (state_reg == ST_INIT) && wr_en;
            if (rd_fire) begin
                rd_data_reg <= rd_word;
                rd_miss_reg <= (rd_word == '0);
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign rd_miss  = rd_miss_reg;
    assign wr_err   = wr_err_reg;
    assign busy     = busy_reg;

endmodule
